// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for the scanning decoder family.
// Holds the controller state encoding, the one-hot helper and the circular
// next-set-bit finder. The helpers work on the widest supported vector
// (MAX_N select bits); callers zero-extend their inputs and size-cast results.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam int MAX_N    = 8;
  localparam int MAX_OUTS = 2 ** MAX_N;

  typedef logic [MAX_N-1:0]    sel_t;
  typedef logic [MAX_OUTS-1:0] vec_t;

  typedef struct packed {
    sel_t idx;      // selected position
    logic wrapped;  // nothing set above the start index, so we came round
    logic found;    // at least one participating bit
  } next_t;

  function automatic vec_t onehot(input sel_t index);
    vec_t one;
    one    = '0;
    one[0] = 1'b1;
    return one << index;
  endfunction

  // Lowest set bit strictly above idx; otherwise lowest set bit overall.
  // Only the low 'outs' bits of mask take part.
  function automatic next_t find_next(input vec_t mask, input sel_t idx, input int outs);
    next_t res;
    logic  found_above;
    sel_t  above_idx;
    logic  found_low;
    sel_t  low_idx;
    found_above = 1'b0;
    above_idx   = '0;
    found_low   = 1'b0;
    low_idx     = '0;
    for (int i = 0; i < MAX_OUTS; i++) begin
      if ((i < outs) && mask[i]) begin
        if (!found_low) begin
          found_low = 1'b1;
          low_idx   = sel_t'(i);
        end else begin
          found_low = found_low;
        end
        if (!found_above && (i > int'(idx))) begin
          found_above = 1'b1;
          above_idx   = sel_t'(i);
        end else begin
          found_above = found_above;
        end
      end else begin
        found_low = found_low;
      end
    end
    res.found   = found_low;
    res.wrapped = found_low && !found_above;
    res.idx     = found_above ? above_idx : low_idx;
    return res;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// decoder_scan_if: select/scan bus between a controller (master) and the
// decoder (slave).
//   E, mode, In, mask : master -> slave controls
//   Out, idx, wrap    : slave -> master registered results
interface decoder_scan_if #(
  parameter int N = 3
) ();
  localparam int OUTS = 2 ** N;

  logic            E;
  logic            mode;
  logic [N-1:0]    In;
  logic [OUTS-1:0] mask;
  logic [OUTS-1:0] Out;
  logic [N-1:0]    idx;
  logic            wrap;

  modport master (output E, mode, In, mask, input Out, idx, wrap);
  modport slave  (input E, mode, In, mask, output Out, idx, wrap);
endinterface

// File: rtl/decoder_next_sel.sv
// decoder_next_sel: combinational circular priority finder.
//   mask     : participating positions
//   idx      : start position (search is strictly above it, circularly)
//   next_idx : chosen position
//   wrapped  : the search came round to the low end
//   any      : mask has at least one bit set
module decoder_next_sel
  import decoder_pkg::*;
#(
  parameter int N = 3,
  localparam int OUTS = 2 ** N
) (
  input  logic [OUTS-1:0] mask,
  input  logic [N-1:0]    idx,
  output logic [N-1:0]    next_idx,
  output logic            wrapped,
  output logic            any
);

  next_t res_s;

  // Widen to the package helper, then narrow the chosen index back.
  always_comb begin
    res_s    = find_next(vec_t'(mask), sel_t'(idx), OUTS);
    next_idx = N'(res_s.idx);
    wrapped  = res_s.wrapped;
    any      = res_s.found;
  end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with enable, direct
// decode and autonomous masked scan at a DWELL-cycle rate.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decoder_scan_if slave (E, mode, In, mask in; Out, idx, wrap out)
// N must not exceed decoder_pkg::MAX_N.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_if.slave  bus
);

  localparam int OUTS = 2 ** N;
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [OUTS-1:0] out_q, out_d;
  logic            wrap_q, wrap_d;
  // Set while scanning with an empty mask: the next non-empty mask restarts
  // the scan from its lowest bit instead of advancing from the held idx.
  logic            parked_q, parked_d;

  logic            entering_s;
  logic [N-1:0]    sel_from_s;
  logic [N-1:0]    next_idx_s;
  logic            wrapped_s;
  logic            any_s;

  assign entering_s = (state_q != ST_SCAN) || parked_q;
  // Searching from the top index makes the finder return the lowest set bit.
  assign sel_from_s = entering_s ? {N{1'b1}} : idx_q;

  decoder_next_sel #(.N(N)) u_next_sel (
    .mask     (bus.mask),
    .idx      (sel_from_s),
    .next_idx (next_idx_s),
    .wrapped  (wrapped_s),
    .any      (any_s)
  );

  // Next state from E/mode, then the register updates for that state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    out_d    = out_q;
    wrap_d   = 1'b0;
    parked_d = parked_q;

    if (!bus.E) begin
      state_d = ST_IDLE;
    end else if (!bus.mode) begin
      state_d = ST_DIRECT;
    end else begin
      state_d = ST_SCAN;
    end

    case (state_d)
      ST_IDLE: begin
        out_d    = '0;
        cnt_d    = '0;
        parked_d = 1'b0;
      end
      ST_DIRECT: begin
        out_d    = OUTS'(onehot(sel_t'(bus.In)));
        idx_d    = bus.In;
        cnt_d    = '0;
        parked_d = 1'b0;
      end
      ST_SCAN: begin
        if (!any_s) begin
          out_d    = '0;
          cnt_d    = '0;
          parked_d = 1'b1;
        end else if (entering_s) begin
          idx_d    = next_idx_s;
          out_d    = OUTS'(onehot(sel_t'(next_idx_s)));
          cnt_d    = '0;
          parked_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          idx_d  = next_idx_s;
          out_d  = OUTS'(onehot(sel_t'(next_idx_s)));
          wrap_d = wrapped_s;
          cnt_d  = '0;
        end else begin
          // Masking the held position lets a cleared bit drop Out at once.
          cnt_d = cnt_q + CW'(1);
          out_d = OUTS'(onehot(sel_t'(idx_q))) & bus.mask;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        out_d    = '0;
        cnt_d    = '0;
        idx_d    = '0;
        parked_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      out_q    <= '0;
      wrap_q   <= 1'b0;
      parked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      wrap_q   <= wrap_d;
      parked_q <= parked_d;
    end
  end

  assign bus.Out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed self-checking bench for decoder_scan (N=3, DWELL=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// so each check sees the result of the edge that sampled the previous inputs.
module tb_decoder_scan;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] full_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] sparse_seq [4] = '{8'h04, 8'h10, 8'h80, 8'h04};

  decoder_scan_if #(.N(3)) bus ();

  decoder_scan #(.N(3), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.E = 1'b0; bus.mode = 1'b0; bus.In = 3'd0; bus.mask = 8'h00;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.Out !== 8'h00 || bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin
        $display("FAIL reset: cycle %0d Out=%h idx=%0d wrap=%b, expected Out=00 idx=0 wrap=0",
                 c, bus.Out, bus.idx, bus.wrap);
        failures++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    bus.E = 1'b1; bus.mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.In = 3'(k);
      step();
      checks++;
      if (bus.Out !== full_seq[k] || bus.idx !== 3'(k) || bus.wrap !== 1'b0) begin
        $display("FAIL direct: In=%0d Out=%h idx=%0d wrap=%b, expected Out=%h idx=%0d wrap=0",
                 k, bus.Out, bus.idx, bus.wrap, full_seq[k], k);
        failures++;
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] exp [5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h20};
    logic       e_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.In = 3'd5;
    for (int c = 0; c < 5; c++) begin
      bus.E = e_seq[c];
      step();
      checks++;
      if (bus.Out !== exp[c]) begin
        $display("FAIL enable: cycle %0d Out=%h expected %h", c, bus.Out, exp[c]);
        failures++;
      end
    end
  endtask

  task automatic test_full_scan();
    logic exp_wrap;
    bus.E = 1'b1; bus.mode = 1'b1; bus.mask = 8'hFF;
    for (int c = 0; c <= 32; c++) begin
      step();
      exp_wrap = (c == 32);
      checks++;
      if (bus.Out !== full_seq[(c / 4) % 8] || bus.wrap !== exp_wrap) begin
        $display("FAIL full_scan: cycle %0d Out=%h wrap=%b expected Out=%h wrap=%b",
                 c, bus.Out, bus.wrap, full_seq[(c / 4) % 8], exp_wrap);
        failures++;
      end
    end
  endtask

  task automatic test_sparse();
    logic exp_wrap;
    bus.E = 1'b0;
    step();
    bus.mask = 8'b1001_0100; bus.E = 1'b1; bus.mode = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      exp_wrap = (c == 12);
      checks++;
      if (bus.Out !== sparse_seq[c / 4] || bus.wrap !== exp_wrap) begin
        $display("FAIL sparse: cycle %0d Out=%h wrap=%b expected Out=%h wrap=%b",
                 c, bus.Out, bus.wrap, sparse_seq[c / 4], exp_wrap);
        failures++;
      end
    end
  endtask

  task automatic test_mask_edges();
    // Expected Out over: entry, cnt1, [clear bit 0] cnt2, cnt3, advance.
    logic [7:0] exp [5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
    bus.E = 1'b0;
    step();
    bus.mask = 8'hFF; bus.E = 1'b1; bus.mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.mask = 8'hFE;
      step();
      checks++;
      if (bus.Out !== exp[c] || bus.wrap !== 1'b0) begin
        $display("FAIL mask_clear: cycle %0d Out=%h wrap=%b expected Out=%h wrap=0",
                 c, bus.Out, bus.wrap, exp[c]);
        failures++;
      end
    end
    checks++;
    if (bus.idx !== 3'd1) begin
      $display("FAIL mask_clear_idx: idx=%0d expected 1", bus.idx);
      failures++;
    end
    bus.mask = 8'h00;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (bus.Out !== 8'h00 || bus.wrap !== 1'b0 || bus.idx !== 3'd1) begin
        $display("FAIL mask_zero: cycle %0d Out=%h wrap=%b idx=%0d expected Out=00 wrap=0 idx=1",
                 c, bus.Out, bus.wrap, bus.idx);
        failures++;
      end
    end
    bus.mask = 8'h08;
    step();
    checks++;
    if (bus.Out !== 8'h08 || bus.idx !== 3'd3 || bus.wrap !== 1'b0) begin
      $display("FAIL mask_restore: Out=%h idx=%0d wrap=%b expected Out=08 idx=3 wrap=0",
               bus.Out, bus.idx, bus.wrap);
      failures++;
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] exp [5] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
    bus.E = 1'b0;
    step();
    bus.mask = 8'hFF; bus.E = 1'b1; bus.mode = 1'b1;
    for (int c = 0; c < 15; c++) step();
    checks++;
    if (bus.Out !== 8'h08 || bus.idx !== 3'd3) begin
      $display("FAIL pre_reset: Out=%h idx=%0d expected Out=08 idx=3", bus.Out, bus.idx);
      failures++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.Out !== 8'h00 || bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin
      $display("FAIL mid_reset: Out=%h idx=%0d wrap=%b expected Out=00 idx=0 wrap=0",
               bus.Out, bus.idx, bus.wrap);
      failures++;
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus.Out !== exp[c] || bus.wrap !== 1'b0) begin
        $display("FAIL restart: cycle %0d Out=%h wrap=%b expected Out=%h wrap=0",
                 c, bus.Out, bus.wrap, exp[c]);
        failures++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_direct();
    test_enable();
    test_full_scan();
    test_sparse();
    test_mask_edges();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with enable, a direct mode and an autonomous scan mode. In scan mode, scan mode steps a single active output through all unmasked positions at a programmable dwell rate. This is the next-generation select-line driver, replacing the fixed 3-to-8 combinational decoder. Targets include multiplexed displays, row strobes and chip-select sequencing.

## Interface
Parameters:
- N, 3, select width; OUTS = 2**N outputs (derived, not overridable)
- DWELL, 4, cycles each output stays active in scan mode; legal range 1..256

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- E  in  1  enable; 0 forces all outputs low
- mode  in  1  0 = direct decode, 1 = scan
- In  in  N  select index, used in direct mode
- mask  in  OUTS  scan-mode participation; bit i = 1 means output i is visited
- Out  out  OUTS  registered one-hot (or all-zero) output
- idx  out  N  registered index of the current or last active output
- wrap  out  1  one-cycle pulse when the scan wraps from the highest visited index back to the lowest

## Operation
- State register has three states: IDLE, DIRECT and SCAN. It is evaluated each edge from the sampled E and mode.
  - E=0: go to IDLE.
  - E=1, mode=0: go to DIRECT.
  - E=1, mode=1: go to SCAN.
- IDLE:
  - Out <= 0, cnt <= 0, wrap <= 0.
  - idx holds its value.
- DIRECT:
  - Out <= 1<<In and idx <= In on every edge.
  - mask is ignored; wrap <= 0.
- SCAN entry (from IDLE or DIRECT, or on leaving reset straight into scan):
  - idx <= lowest set bit of mask; Out <= 1<<that index; cnt <= 0.
  - No wrap on entry.
- SCAN steady state:
  - cnt increments every cycle.
  - When cnt == DWELL-1: cnt <= 0, and idx advances to the next set mask bit strictly above idx, circularly.
  - If the advance wraps (new idx <= old idx), wrap <= 1 for exactly one cycle.
- Only one unmasked bit: idx stays put, Out stays constant, wrap pulses once every DWELL cycles.
- mask all zero in SCAN:
  - Out <= 0, idx holds, cnt holds at 0, no wrap.
  - When any bit becomes set, the scan resumes as a fresh entry (lowest set bit).
- Mask change mid-scan:
  - Out <= (1<<idx) & mask, so a cleared current bit drops Out to 0 on the next edge.
  - The advance still occurs at the normal dwell boundary, using the current mask.
- Mode switch mid-scan: DIRECT takes effect on the next edge, and cnt is cleared.
- Width rules:
  - cnt width = max(1, clog2(DWELL)).
  - idx arithmetic is modulo OUTS.
  - In is always in range, so no invalid-select handling is required.

## Timing
- Reset values: Out = 0, idx = 0, wrap = 0, cnt = 0, state = IDLE. A synchronous rst mid-scan lands these values on the same edge; rst has priority over everything.
- Latency is one cycle throughout:
  - Direct mode: In/E change to Out change.
  - Scan entry: first output active on the edge that samples E=1 and mode=1.
  - E deassertion: Out = 0 one edge later.
- Each scan position is active for exactly DWELL consecutive cycles, provided mask is stable.
- wrap is asserted in the same cycle Out shows the lowest index after the wrap.
- DWELL=1: a new position every cycle. With a full mask, wrap fires every OUTS cycles.

## Structure
- Shared package decoder_pkg holds:
  - the state encoding constants (IDLE, DIRECT, SCAN);
  - the onehot(index) function;
  - the find_next(mask, idx) function: lowest set bit above idx, else lowest set bit overall, plus a found flag.
- One sub-module, decoder_next_sel: a combinational circular priority finder (mask, idx → next_idx, wrapped, any). It is instantiated once in decoder_scan and is reusable by other sequencers.
- The top level contains the state register, dwell counter and output registers only.

## Test plan
All scenarios use N=3 and DWELL=4.
- Reset/direct:
  - rst for 2 cycles, then E=1, mode=0, In stepped through 0..7, one per cycle. Out = 0 during reset.
  - Out then follows 8'h01, 8'h02 … 8'h80, each one cycle after its In value; idx = In delayed by one cycle.
- Enable gating: in direct mode with In=5, drop E for 3 cycles. Out = 8'h20, then 8'h00 one cycle after E falls, then 8'h20 one cycle after E rises.
- Full scan: mask = 8'hFF, mode=1.
  - Out = 8'h01 for 4 cycles, 8'h02 for 4 cycles, … 8'h80 for 4 cycles, then 8'h01 again.
  - wrap is high only in the first cycle of the return to 8'h01 (cycle 32 after entry).
- Sparse mask: mask = 8'b1001_0100. The sequence is 8'h04 → 8'h10 → 8'h80 → 8'h04, each for 4 cycles, with wrap on the return to 8'h04.
- Mask edge cases:
  - Clear the current bit mid-dwell: Out = 0 next cycle, advance at the normal boundary.
  - mask = 0: Out stays 0 and wrap never fires. Restoring mask = 8'h08 gives Out = 8'h08 one cycle later.
- Reset mid-scan: assert rst at cnt=2 on index 3. The next edge gives Out=0, idx=0, wrap=0. Releasing rst with E=1, mode=1 and a full mask restarts at 8'h01 with a full 4-cycle dwell.
